axis_width_adapter: RTL and testbench

// - AXI4-Stream width upsizer. Packs narrow slave beats (default 8 bit) into wide master words (default 32 bit).
// - Sits between the UDP checksum generator's 8-bit payload output and the 32-bit packet datapath.
// - Preserves frame boundaries via tlast; marks valid bytes of a short final word via m_axis_tkeep.

---
 rtl/axis_width_adapter.sv | 144 ++++++++++++++
 tb/tb_axis_width_adapter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_adapter.sv
// axis_width_adapter: AXI4-Stream upsizer that packs S_DATA_WIDTH beats into M_DATA_WIDTH words.
// Latency: a word is valid 1 cycle after its last beat is accepted (when the output register is free).
// Backpressure: an accumulator fills behind a held output word; s_axis_tready drops only when the
//   accumulator holds a complete word and the output register has not been taken.
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   s_axis_t{data,valid,ready,last,user}   narrow slave stream
//   m_axis_t{data,keep,valid,ready,last,user} wide master stream; tkeep marks valid bytes,
//                            tuser is the OR of tuser over all beats packed into the word
module axis_width_adapter #(
  parameter int S_DATA_WIDTH = 8,
  parameter int M_DATA_WIDTH = 32,
  parameter int USER_WIDTH   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser
);

  localparam int RATIO  = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int S_KEEP = S_DATA_WIDTH / 8;
  localparam int M_KEEP = M_DATA_WIDTH / 8;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // Accumulator: word under construction, or a finished word waiting for the output register.
  logic [M_DATA_WIDTH-1:0] acc_data;
  logic [M_KEEP-1:0]       acc_keep;
  logic [USER_WIDTH-1:0]   acc_user;
  logic                    acc_last;
  logic                    acc_full;
  logic [LANE_W-1:0]       lane;

  // Output register driving m_axis_*.
  logic [M_DATA_WIDTH-1:0] out_data;
  logic [M_KEEP-1:0]       out_keep;
  logic [USER_WIDTH-1:0]   out_user;
  logic                    out_last;
  logic                    out_vld;

  logic                    out_free;
  logic                    s_fire;
  logic                    beat_done;
  logic [M_DATA_WIDTH-1:0] nxt_data;
  logic [M_KEEP-1:0]       nxt_keep;
  logic [USER_WIDTH-1:0]   nxt_user;

  // Output register can take a new word this cycle (empty, or being consumed).
  assign out_free      = !out_vld || m_axis_tready;
  assign s_axis_tready = !acc_full || out_free;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tvalid = out_vld;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;

  // Merge the incoming beat into the accumulator. Lane 0 starts a fresh word, so the
  // other lanes, keep and user are cleared; a full accumulator always sits at lane 0,
  // which lets a new word start while the finished one is handed to the output.
  always_comb begin
    nxt_data = (lane == '0) ? '0 : acc_data;
    nxt_keep = (lane == '0) ? '0 : acc_keep;
    nxt_user = ((lane == '0) ? '0 : acc_user) | s_axis_tuser;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        nxt_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
        nxt_keep[i*S_KEEP +: S_KEEP]             = '1;
      end
    end
    beat_done = s_fire && ((lane == LAST_LANE) || s_axis_tlast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_user <= '0;
      acc_last <= 1'b0;
      acc_full <= 1'b0;
      lane     <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_user <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      // A parked word leaves the accumulator whenever the output register frees up.
      if (acc_full && out_free) begin
        acc_full <= 1'b0;
      end

      if (s_fire) begin
        if (beat_done) begin
          lane <= '0;
          // Park the finished word if the output register is busy or is being
          // loaded from the accumulator in this same cycle.
          if (!out_free || acc_full) begin
            acc_data <= nxt_data;
            acc_keep <= nxt_keep;
            acc_user <= nxt_user;
            acc_last <= s_axis_tlast;
            acc_full <= 1'b1;
          end
        end else begin
          lane     <= LANE_W'(lane + 1'b1);
          acc_data <= nxt_data;
          acc_keep <= nxt_keep;
          acc_user <= nxt_user;
        end
      end

      if (out_free) begin
        if (acc_full) begin
          out_data <= acc_data;
          out_keep <= acc_keep;
          out_user <= acc_user;
          out_last <= acc_last;
          out_vld  <= 1'b1;
        end else if (beat_done) begin
          out_data <= nxt_data;
          out_keep <= nxt_keep;
          out_user <= nxt_user;
          out_last <= s_axis_tlast;
          out_vld  <= 1'b1;
        end else begin
          out_vld  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_width_adapter.sv
// tb_axis_width_adapter: directed stimulus for the 8->32 bit AXIS upsizer.
// A byte-queue model predicts each packed word; a negedge monitor checks every output
// transfer and hold stability, and each scenario also checks hand-computed literal words.
module tb_axis_width_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast  = 1'b0;
  logic [0:0]  s_tuser  = '0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [0:0]  m_tuser;

  always #5 clk = ~clk;

  axis_width_adapter #(
    .S_DATA_WIDTH(8),
    .M_DATA_WIDTH(32),
    .USER_WIDTH  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  word_t      exp_q[$];
  word_t      obs_q[$];
  word_t      lit_q[$];
  logic [7:0] part_bytes[$];
  logic       part_user = 1'b0;
  bit         saw_s_stall = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
    word_t w;
    w.data = d; w.keep = k; w.last = l; w.user = u;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Model: collect accepted bytes; a word closes after 4 bytes or on tlast.
  task automatic monitor();
    word_t cur, held, e;
    bit    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      cur = mk(m_tdata, m_tkeep, m_tlast, m_tuser[0]);
      if (rst) begin
        exp_q.delete();
        obs_q.delete();
        part_bytes.delete();
        part_user = 1'b0;
        hold_chk  = 1'b0;
        continue;
      end
      if (hold_chk) begin
        check("hold_valid", 64'(m_tvalid), 64'(1));
        check("hold_word", 64'(cur), 64'(held));
      end
      hold_chk = m_tvalid && !m_tready;
      held     = cur;
      if (!s_tready) saw_s_stall = 1'b1;
      if (m_tvalid && m_tready) begin
        obs_q.push_back(cur);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          e = exp_q.pop_front();
          check("model_word", 64'(cur), 64'(e));
        end
      end
      if (s_tvalid && s_tready) begin
        part_bytes.push_back(s_tdata);
        part_user = part_user | s_tuser[0];
        if (part_bytes.size() == 4 || s_tlast) begin
          e.data = '0;
          for (int k = 0; k < part_bytes.size(); k++)
            e.data = e.data + (32'(part_bytes[k]) << (8 * k));
          e.keep = 4'((1 << part_bytes.size()) - 1);
          e.last = s_tlast;
          e.user = part_user;
          exp_q.push_back(e);
          part_bytes.delete();
          part_user = 1'b0;
        end
      end
    end
  endtask

  // Present one beat; returns after the edge that accepts it (+1 time unit).
  task automatic send_beat(input logic [7:0] d, input logic l, input logic u, output int waited);
    bit done = 1'b0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (s_tready) done = 1'b1;
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          fail_now("send_timeout");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_seq(input int n, input logic [7:0] first, input bit inc,
                          input int user_idx, input bit last_at_end, output int cycles);
    int w;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(inc ? 8'(first + i) : first, (last_at_end && i == n - 1),
                (i == user_idx), w);
      cycles += 1 + w;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((m_tvalid || exp_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic expect_words(input string name);
    check({name, "_count"}, 64'(obs_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < obs_q.size() && i < lit_q.size(); i++)
      check(name, 64'(obs_q[i]), 64'(lit_q[i]));
    obs_q.delete();
    lit_q.delete();
  endtask

  initial begin
    int cyc;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tdata",  64'(m_tdata),  64'(0));
    check("rst_m_tkeep",  64'(m_tkeep),  64'(0));
    check("rst_m_tlast",  64'(m_tlast),  64'(0));
    check("rst_m_tuser",  64'(m_tuser),  64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // 18 bytes of 0x11: four full words, then a 2-byte short word.
    send_seq(18, 8'h11, 1'b0, -1, 1'b1, cyc);
    check("t18_cycles", 64'(cyc), 64'(18));
    drain();
    for (int i = 0; i < 4; i++) lit_q.push_back(mk(32'h11111111, 4'hF, 1'b0, 1'b0));
    lit_q.push_back(mk(32'h00001111, 4'h3, 1'b1, 1'b0));
    expect_words("t18_word");

    // Bytes 01..08 back to back.
    send_seq(8, 8'h01, 1'b1, -1, 1'b1, cyc);
    check("t8_no_idle", 64'(cyc), 64'(8));
    drain();
    lit_q.push_back(mk(32'h04030201, 4'hF, 1'b0, 1'b0));
    lit_q.push_back(mk(32'h08070605, 4'hF, 1'b1, 1'b0));
    expect_words("t8_word");

    // Same frame, first word held for 5 cycles.
    m_tready    = 1'b0;
    saw_s_stall = 1'b0;
    fork
      begin
        for (int t = 0; t < 100 && !m_tvalid; t++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join_none
    send_seq(8, 8'h01, 1'b1, -1, 1'b1, cyc);
    drain();
    check("stall_s_tready_dropped", 64'(saw_s_stall), 64'(1));
    lit_q.push_back(mk(32'h04030201, 4'hF, 1'b0, 1'b0));
    lit_q.push_back(mk(32'h08070605, 4'hF, 1'b1, 1'b0));
    expect_words("stall_word");

    // Single-byte frame: valid exactly one cycle after acceptance.
    send_beat(8'hAB, 1'b1, 1'b0, cyc);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("single_latency_vld", 64'(m_tvalid), 64'(1));
    check("single_latency_dat", 64'(m_tdata),  64'(32'h000000AB));
    drain();
    lit_q.push_back(mk(32'h000000AB, 4'h1, 1'b1, 1'b0));
    expect_words("single_word");

    // tuser on byte 2 flags only its own word.
    send_seq(4, 8'h21, 1'b1, 1, 1'b1, cyc);
    send_seq(4, 8'h31, 1'b1, -1, 1'b1, cyc);
    drain();
    lit_q.push_back(mk(32'h24232221, 4'hF, 1'b1, 1'b1));
    lit_q.push_back(mk(32'h34333231, 4'hF, 1'b1, 1'b0));
    expect_words("tuser_word");

    // Reset with a held word and 2 bytes of a partial word.
    m_tready = 1'b0;
    send_seq(4, 8'h41, 1'b1, -1, 1'b0, cyc);
    send_seq(2, 8'h51, 1'b1, -1, 1'b0, cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("midrst_m_tkeep",  64'(m_tkeep),  64'(0));
    check("midrst_m_tdata",  64'(m_tdata),  64'(0));
    rst = 1'b0;
    m_tready = 1'b1;
    @(posedge clk); #1;
    send_seq(4, 8'hA0, 1'b1, -1, 1'b1, cyc);
    drain();
    lit_q.push_back(mk(32'hA3A2A1A0, 4'hF, 1'b1, 1'b0));
    expect_words("postrst_word");

    check("model_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
